control_unit_seq: RTL and testbench

//  Registered ID-stage control unit. Decodes Mode/Opcode/S into EX/MEM/WB controls with 1-cycle latency.

---
 rtl/control_unit_seq.sv | 182 ++++++++++++++++++
 tb/tb_control_unit_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq.sv
// rtl/control_unit_seq.sv - registered ID-stage control unit with LDM/STM block-transfer sequencer
module control_unit_seq #(
    parameter int REG_CNT    = 16,
    parameter int REG_IDX_W  = 4,
    parameter int OFFSET_W   = 12,
    parameter int WORD_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 In_Valid,
    input  logic [1:0]           Mode,
    input  logic [3:0]           Opcode,
    input  logic                 S_in,
    input  logic                 Cond_Pass,
    input  logic [REG_CNT-1:0]   Reg_List,
    input  logic                 Freeze,
    input  logic                 Flush,
    output logic                 WB_EN,
    output logic                 MEM_R_EN,
    output logic                 MEM_W_EN,
    output logic                 B,
    output logic                 S_out,
    output logic [3:0]           EXE_CMD,
    output logic                 Out_Valid,
    output logic [REG_IDX_W-1:0] Beat_Reg,
    output logic [OFFSET_W-1:0]  Beat_Offset,
    output logic                 Last_Beat,
    output logic                 Busy
);
    localparam int CNT_W = REG_IDX_W + 1;

    typedef enum logic {IDLE = 1'b0, BLOCK = 1'b1} state_t;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s_out;
        logic [3:0]           exe_cmd;
        logic                 out_valid;
        logic [REG_IDX_W-1:0] beat_reg;
        logic [OFFSET_W-1:0]  beat_offset;
        logic                 last_beat;
    } ctrl_t;

    state_t             state, state_nxt;
    logic [REG_CNT-1:0] pending, pending_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               blk_load, blk_load_nxt;
    ctrl_t              ctrl_q, ctrl_d;
    logic               consume;
    logic [REG_CNT-1:0] pend_rest, list_rest;

    function automatic logic [REG_CNT-1:0] low_bit(input logic [REG_CNT-1:0] v);
        return v & (~v + REG_CNT'(1));
    endfunction

    function automatic logic [REG_IDX_W-1:0] low_idx(input logic [REG_CNT-1:0] v);
        logic [REG_IDX_W-1:0] idx;
        idx = '0;
        for (int i = REG_CNT - 1; i >= 0; i--)
            if (v[i]) idx = REG_IDX_W'(i);
        return idx;
    endfunction

    function automatic ctrl_t beat_ctrl(input logic load, input logic [REG_IDX_W-1:0] idx,
                                        input logic [CNT_W-1:0] n);
        ctrl_t       c;
        logic [31:0] off;
        c             = '0;
        off           = 32'(n) * 32'(WORD_BYTES);
        c.wb_en       = load;
        c.mem_r_en    = load;
        c.mem_w_en    = !load;
        c.exe_cmd     = 4'b0010;
        c.out_valid   = 1'b1;
        c.beat_reg    = idx;
        c.beat_offset = off[OFFSET_W-1:0];
        return c;
    endfunction

    // Compare-type opcodes always update flags and never write back.
    function automatic ctrl_t dp_ctrl(input logic [3:0] op, input logic s);
        ctrl_t c;
        c           = '0;
        c.out_valid = 1'b1;
        case (op)
            4'b1101: begin c.exe_cmd = 4'b0001; c.wb_en = 1'b1; c.s_out = s; end
            4'b1111: begin c.exe_cmd = 4'b1001; c.wb_en = 1'b1; c.s_out = s; end
            4'b0100: begin c.exe_cmd = 4'b0010; c.wb_en = 1'b1; c.s_out = s; end
            4'b0101: begin c.exe_cmd = 4'b0011; c.wb_en = 1'b1; c.s_out = s; end
            4'b0010: begin c.exe_cmd = 4'b0100; c.wb_en = 1'b1; c.s_out = s; end
            4'b0110: begin c.exe_cmd = 4'b0101; c.wb_en = 1'b1; c.s_out = s; end
            4'b0000: begin c.exe_cmd = 4'b0110; c.wb_en = 1'b1; c.s_out = s; end
            4'b1100: begin c.exe_cmd = 4'b0111; c.wb_en = 1'b1; c.s_out = s; end
            4'b0001: begin c.exe_cmd = 4'b1000; c.wb_en = 1'b1; c.s_out = s; end
            4'b1010: begin c.exe_cmd = 4'b0100; c.s_out = 1'b1; end
            4'b1000: begin c.exe_cmd = 4'b0110; c.s_out = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    assign consume   = (state == IDLE) && In_Valid && !Freeze && !Flush;
    assign pend_rest = pending & ~low_bit(pending);
    assign list_rest = Reg_List & ~low_bit(Reg_List);

    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        beat_cnt_nxt = beat_cnt;
        blk_load_nxt = blk_load;
        ctrl_d       = '0;
        if (Flush) begin
            state_nxt    = IDLE;
            pending_nxt  = '0;
            beat_cnt_nxt = '0;
        end else if (state == BLOCK) begin
            if (!Freeze) begin
                ctrl_d           = beat_ctrl(blk_load, low_idx(pending), beat_cnt);
                ctrl_d.last_beat = (pend_rest == '0);
                pending_nxt      = pend_rest;
                beat_cnt_nxt     = beat_cnt + CNT_W'(1);
                if (pend_rest == '0) state_nxt = IDLE;
            end
        end else if (consume && Cond_Pass) begin
            case (Mode)
                2'b00: ctrl_d = dp_ctrl(Opcode, S_in);
                2'b01: begin
                    ctrl_d           = beat_ctrl(S_in, '0, '0);
                    ctrl_d.last_beat = 1'b1;
                end
                2'b10: begin
                    ctrl_d.b         = 1'b1;
                    ctrl_d.out_valid = 1'b1;
                end
                2'b11: begin
                    // An empty register list issues nothing.
                    if (Reg_List != '0) begin
                        ctrl_d           = beat_ctrl(S_in, low_idx(Reg_List), '0);
                        ctrl_d.last_beat = (list_rest == '0);
                        pending_nxt      = list_rest;
                        beat_cnt_nxt     = CNT_W'(1);
                        blk_load_nxt     = S_in;
                        if (list_rest != '0) state_nxt = BLOCK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            beat_cnt <= '0;
            blk_load <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            beat_cnt <= beat_cnt_nxt;
            blk_load <= blk_load_nxt;
            ctrl_q   <= ctrl_d;
        end
    end

    assign WB_EN       = ctrl_q.wb_en;
    assign MEM_R_EN    = ctrl_q.mem_r_en;
    assign MEM_W_EN    = ctrl_q.mem_w_en;
    assign B           = ctrl_q.b;
    assign S_out       = ctrl_q.s_out;
    assign EXE_CMD     = ctrl_q.exe_cmd;
    assign Out_Valid   = ctrl_q.out_valid;
    assign Beat_Reg    = ctrl_q.beat_reg;
    assign Beat_Offset = ctrl_q.beat_offset;
    assign Last_Beat   = ctrl_q.last_beat;
    assign Busy        = (state == BLOCK);

endmodule

// File: tb/tb_control_unit_seq.sv
// tb/tb_control_unit_seq.sv - self-checking bench for control_unit_seq
module tb_control_unit_seq;
    localparam int REG_CNT    = 16;
    localparam int REG_IDX_W  = 4;
    localparam int OFFSET_W   = 12;
    localparam int WORD_BYTES = 4;

    logic        clk = 1'b0;
    logic        rst, In_Valid, S_in, Cond_Pass, Freeze, Flush;
    logic [1:0]  Mode;
    logic [3:0]  Opcode;
    logic [15:0] Reg_List;
    logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S_out, Out_Valid, Last_Beat, Busy;
    logic [3:0]  EXE_CMD;
    logic [3:0]  Beat_Reg;
    logic [11:0] Beat_Offset;

    always #5 clk = ~clk;

    control_unit_seq #(
        .REG_CNT(REG_CNT), .REG_IDX_W(REG_IDX_W), .OFFSET_W(OFFSET_W), .WORD_BYTES(WORD_BYTES)
    ) dut (
        .clk(clk), .rst(rst), .In_Valid(In_Valid), .Mode(Mode), .Opcode(Opcode), .S_in(S_in),
        .Cond_Pass(Cond_Pass), .Reg_List(Reg_List), .Freeze(Freeze), .Flush(Flush),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S_out(S_out),
        .EXE_CMD(EXE_CMD), .Out_Valid(Out_Valid), .Beat_Reg(Beat_Reg), .Beat_Offset(Beat_Offset),
        .Last_Beat(Last_Beat), .Busy(Busy)
    );

    typedef struct packed {
        logic       wb, mr, mw, b, s;
        logic [3:0] exe;
        logic       v;
        logic [3:0] breg;
        logic [11:0] off;
        logic       last, busy;
    } outs_t;

    typedef struct {
        string       name;
        logic [1:0]  md;
        logic [3:0]  op;
        logic        s, cp;
        logic [15:0] rl;
        outs_t       exp;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    outs_t got, m_exp;
    vec_t  tab[$];

    int mq[$];
    int m_beat;
    bit m_load;

    function automatic outs_t mk(input logic wb, mr, mw, b, s, input logic [3:0] exe, input logic v,
                                 input logic [3:0] breg, input logic [11:0] off, input logic last, busy);
        outs_t o;
        o = '{wb: wb, mr: mr, mw: mw, b: b, s: s, exe: exe, v: v, breg: breg, off: off, last: last, busy: busy};
        return o;
    endfunction

    function automatic outs_t beat_e(input logic load, input int idx, input int off, input logic last, busy);
        return mk(load, load, !load, 1'b0, 1'b0, 4'b0010, 1'b1, 4'(idx), 12'(off), last, busy);
    endfunction

    function automatic outs_t dut_outs();
        return mk(WB_EN, MEM_R_EN, MEM_W_EN, B, S_out, EXE_CMD, Out_Valid, Beat_Reg, Beat_Offset, Last_Beat, Busy);
    endfunction

    task automatic check(input string name, input outs_t g, input outs_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, g, e);
        end
    endtask

    // Reference: data-processing opcodes as a lookup table, block transfers as a queue of register numbers.
    function automatic outs_t model_dp(input logic [3:0] op, input logic s);
        int    cmd[16];
        bit    wr[16];
        outs_t o;
        foreach (cmd[i]) begin cmd[i] = -1; wr[i] = 1; end
        cmd[13] = 1; cmd[15] = 9; cmd[4] = 2; cmd[5] = 3; cmd[2] = 4;
        cmd[6] = 5;  cmd[0] = 6;  cmd[12] = 7; cmd[1] = 8;
        cmd[10] = 4; wr[10] = 0; cmd[8] = 6; wr[8] = 0;
        o = '0;
        o.v = 1'b1;
        if (cmd[op] >= 0) begin
            o.exe = 4'(cmd[op]);
            o.wb  = wr[op];
            o.s   = wr[op] ? s : 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(input logic r, iv, input logic [1:0] md, input logic [3:0] op,
                              input logic s, cp, input logic [15:0] rl, input logic fz, fl);
        outs_t e;
        e = '0;
        if (r || fl) begin
            mq.delete();
        end else if (mq.size() > 0) begin
            if (!fz) begin
                e = beat_e(m_load, mq.pop_front(), (m_beat * WORD_BYTES) % (1 << OFFSET_W), 1'b0, 1'b0);
                m_beat++;
                e.last = (mq.size() == 0);
            end
        end else if (iv && !fz && cp) begin
            case (md)
                2'd0: e = model_dp(op, s);
                2'd1: e = beat_e(s, 0, 0, 1'b1, 1'b0);
                2'd2: begin e.b = 1'b1; e.v = 1'b1; end
                default: begin
                    for (int i = 0; i < REG_CNT; i++) if (rl[i]) mq.push_back(i);
                    if (mq.size() > 0) begin
                        m_load = s;
                        m_beat = 1;
                        e = beat_e(s, mq.pop_front(), 0, 1'b0, 1'b0);
                        e.last = (mq.size() == 0);
                    end
                end
            endcase
        end
        e.busy = (mq.size() > 0);
        m_exp = e;
    endtask

    task automatic cycle(input logic r, iv, input logic [1:0] md, input logic [3:0] op,
                         input logic s, cp, input logic [15:0] rl, input logic fz, fl);
        @(negedge clk);
        rst = r; In_Valid = iv; Mode = md; Opcode = op; S_in = s;
        Cond_Pass = cp; Reg_List = rl; Freeze = fz; Flush = fl;
        model_step(r, iv, md, op, s, cp, rl, fz, fl);
        @(posedge clk);
        #1;
        got = dut_outs();
        check("model", got, m_exp);
    endtask

    task automatic issue(input logic [1:0] md, input logic [3:0] op, input logic s, input logic [15:0] rl);
        cycle(1'b0, 1'b1, md, op, s, 1'b1, rl, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic add_vec(input string n, input logic [1:0] md, input logic [3:0] op,
                           input logic s, cp, input logic [15:0] rl, input outs_t e);
        vec_t t;
        t = '{name: n, md: md, op: op, s: s, cp: cp, rl: rl, exp: e};
        tab.push_back(t);
    endtask

    outs_t zero_o, add_o;

    initial begin
        zero_o = '0;
        add_o  = mk(1, 0, 0, 0, 1, 4'b0010, 1, 0, 0, 0, 0);

        add_vec("add",   2'd0, 4'b0100, 1, 1, 0, add_o);
        add_vec("cmp",   2'd0, 4'b1010, 0, 1, 0, mk(0, 0, 0, 0, 1, 4'b0100, 1, 0, 0, 0, 0));
        add_vec("mov",   2'd0, 4'b1101, 0, 1, 0, mk(1, 0, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0));
        add_vec("mvn",   2'd0, 4'b1111, 1, 1, 0, mk(1, 0, 0, 0, 1, 4'b1001, 1, 0, 0, 0, 0));
        add_vec("adc",   2'd0, 4'b0101, 0, 1, 0, mk(1, 0, 0, 0, 0, 4'b0011, 1, 0, 0, 0, 0));
        add_vec("sub",   2'd0, 4'b0010, 1, 1, 0, mk(1, 0, 0, 0, 1, 4'b0100, 1, 0, 0, 0, 0));
        add_vec("sbc",   2'd0, 4'b0110, 0, 1, 0, mk(1, 0, 0, 0, 0, 4'b0101, 1, 0, 0, 0, 0));
        add_vec("and",   2'd0, 4'b0000, 1, 1, 0, mk(1, 0, 0, 0, 1, 4'b0110, 1, 0, 0, 0, 0));
        add_vec("orr",   2'd0, 4'b1100, 0, 1, 0, mk(1, 0, 0, 0, 0, 4'b0111, 1, 0, 0, 0, 0));
        add_vec("eor",   2'd0, 4'b0001, 1, 1, 0, mk(1, 0, 0, 0, 1, 4'b1000, 1, 0, 0, 0, 0));
        add_vec("tst",   2'd0, 4'b1000, 0, 1, 0, mk(0, 0, 0, 0, 1, 4'b0110, 1, 0, 0, 0, 0));
        add_vec("undef", 2'd0, 4'b0011, 1, 1, 0, mk(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
        add_vec("ldr",   2'd1, 4'b0000, 1, 1, 0, beat_e(1, 0, 0, 1, 0));
        add_vec("str",   2'd1, 4'b0000, 0, 1, 0, beat_e(0, 0, 0, 1, 0));
        add_vec("br",    2'd2, 4'b0000, 0, 1, 0, mk(0, 0, 0, 1, 0, 4'b0000, 1, 0, 0, 0, 0));
        add_vec("add_nc",2'd0, 4'b0100, 1, 0, 0, zero_o);
        add_vec("ldm_0", 2'd3, 4'b0000, 1, 1, 16'h0000, zero_o);
        add_vec("ldm_1", 2'd3, 4'b0000, 1, 1, 16'h0010, beat_e(1, 4, 0, 1, 0));

        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset", got, zero_o);

        foreach (tab[i]) begin
            cycle(1'b0, 1'b1, tab[i].md, tab[i].op, tab[i].s, tab[i].cp, tab[i].rl, 1'b0, 1'b0);
            check(tab[i].name, got, tab[i].exp);
        end

        // LDM r0,r2,r5 with an ADD waiting behind it
        issue(2'd3, 0, 1, 16'h0025); check("ldm_b0", got, beat_e(1, 0, 0, 0, 1));
        issue(2'd0, 4'b0100, 1, 0);  check("ldm_b1", got, beat_e(1, 2, 4, 0, 1));
        issue(2'd0, 4'b0100, 1, 0);  check("ldm_b2", got, beat_e(1, 5, 8, 1, 0));
        issue(2'd0, 4'b0100, 1, 0);  check("ldm_add", got, add_o);

        // STM r0,r1 frozen after the first beat
        issue(2'd3, 0, 0, 16'h0003); check("stm_b0", got, beat_e(0, 0, 0, 0, 1));
        cycle(0, 1, 2'd3, 0, 0, 1, 16'h0003, 1, 0);
        check("stm_frz", got, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        idle();                      check("stm_b1", got, beat_e(0, 1, 4, 1, 0));

        // STM full list flushed on the 5th cycle
        issue(2'd3, 0, 0, 16'hFFFF); check("fl_b0", got, beat_e(0, 0, 0, 0, 1));
        for (int i = 1; i < 4; i++) begin
            idle(); check("fl_bn", got, beat_e(0, i, 4 * i, 0, 1));
        end
        cycle(0, 1, 2'd0, 4'b0100, 1, 1, 0, 0, 1); check("fl_bubble", got, zero_o);
        issue(2'd0, 4'b0100, 1, 0);  check("fl_add", got, add_o);

        // reset in the middle of an LDM
        issue(2'd3, 0, 1, 16'h00F0); check("rs_b0", got, beat_e(1, 4, 0, 0, 1));
        idle();                      check("rs_b1", got, beat_e(1, 5, 4, 0, 1));
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0); check("rs_zero", got, zero_o);
        issue(2'd1, 0, 1, 0);        check("rs_ldr", got, beat_e(1, 0, 0, 1, 0));

        // full list: 16 beats, last at offset 60
        issue(2'd3, 0, 1, 16'hFFFF); check("full_b0", got, beat_e(1, 0, 0, 0, 1));
        for (int i = 1; i < REG_CNT; i++) begin
            idle(); check("full_bn", got, beat_e(1, i, 4 * i, i == REG_CNT - 1, i != REG_CNT - 1));
        end

        for (int n = 0; n < 4000; n++) begin
            logic [15:0] rl;
            int sel;
            sel = $urandom_range(0, 9);
            rl = (sel == 0) ? 16'h0 : (sel == 1) ? 16'hFFFF : 16'($urandom & $urandom);
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, 2'($urandom_range(0, 3)),
                  4'($urandom), 1'($urandom), $urandom_range(0, 99) < 85, rl,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
